cache_mem_responder: RTL and testbench
======================================

# cache_mem_responder

Word-addressed main-memory responder for the cache-to-memory request interface. It is the memory-side end of the protocol driven by the instruction/data cache miss logic. It accepts one read or write request at a time, waits a fixed programmable latency, then completes the transaction with a one-cycle ready pulse and, for reads, the returned word. It is used as the backing store in cache simulation and FPGA bring-up, between the cache and the memory array.

## Interface
- ADDR_WIDTH, 10: word-index width; depth = 2^ADDR_WIDTH 32-bit words.
- LATENCY, 4: cycles from request acceptance to ready pulse; legal range 1..255.
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- mem_req_addr  input  32  byte address; word index = mem_req_addr[ADDR_WIDTH+1:2]; bits [1:0] and above ADDR_WIDTH+1 ignored (aliasing).
- mem_req_valid  input  1  request present; initiator holds it and addr/wr/data stable until ready.
- mem_req_wr  input  1  1 = write, 0 = read.
- mem_wr_data  input  32  write data.
- mem_req_data  output  32  read data; valid only while mem_req_ready=1 on a read.
- mem_req_ready  output  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, BUSY, DONE. A down-counter of width clog2(LATENCY+1) is used in BUSY.
- IDLE: on an edge with mem_req_valid=1, latch addr, wr and wr_data.
  - If LATENCY=1, go to DONE.
  - Otherwise, go to BUSY with the counter = LATENCY-2.
- BUSY: each edge with mem_req_valid=1:
  - if counter=0, go to DONE;
  - else decrement the counter.
- BUSY abort: an edge with mem_req_valid=0 returns the FSM to IDLE. No write is performed and no ready pulse is issued.
- Entering DONE (commit edge):
  - Write: the array word at the latched index is written with the latched data. mem_req_data holds its previous value.
  - Read: mem_req_data is loaded with the array word at the latched index.
- DONE: mem_req_ready=1 for exactly this one cycle. The next edge always goes to IDLE, regardless of mem_req_valid; that edge is the completion handshake.
- Request inputs that change during BUSY or DONE are ignored, because the latched copies are used.
- Array contents are not cleared by rst. Power-up contents are all zero.
- Reset values: state=IDLE, counter=0, mem_req_ready=0, mem_req_data=32'h0.
- rst mid-transaction: the FSM returns to IDLE and an uncommitted write is dropped. A write already committed on an earlier edge persists.

## Timing
- Request sampled at the end of cycle C0 → mem_req_ready high during cycle C_LATENCY. The read data is valid in that same cycle.
- The earliest next acceptance is the end of cycle C_LATENCY+1, which gives one transaction per LATENCY+1 cycles.
- mem_req_ready is registered and never high for two consecutive cycles.
- A read that follows a write to the same address returns the newly written data, because the commit precedes the next acceptance.

## Test plan
- Reset: hold rst for 3 cycles with mem_req_valid=1 → mem_req_ready=0 and mem_req_data=0 throughout. Release rst → request accepted on the first edge after release.
- Write then read, LATENCY=4:
  - Write addr 0x0000_0010, data 0xDEAD_BEEF → ready high exactly 4 cycles after acceptance, one cycle wide.
  - Read addr 0x0000_0010 → mem_req_data=0xDEAD_BEEF while ready=1.
- Aliasing:
  - Write 0x1234_5678 to addr 0x0000_1013 (index 4 with ADDR_WIDTH=10) → read from addr 0x0000_0010 returns 0x1234_5678.
  - Read from addr 0x0000_0014 → returns 0.
- Back-to-back: hold mem_req_valid=1 continuously for 3 reads → ready pulses spaced exactly LATENCY+1=5 cycles apart.
- Abort: start a write of 0xAAAA_AAAA to addr 0x20, then drop valid 2 cycles after acceptance → no ready pulse. A later read of 0x20 returns its prior value.
- LATENCY=1 build: read → ready in the cycle immediately after acceptance. Also assert rst during DONE → ready deasserts next cycle and state=IDLE.

Source files
------------

// File: rtl/cache_mem_responder.sv
// Word-addressed memory responder for the cache miss interface: accepts one
// read/write at a time and completes it with a ready pulse LATENCY cycles later.
module cache_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_mem_req_addr,
  input  logic        i_mem_req_valid,
  input  logic        i_mem_req_wr,
  input  logic [31:0] i_mem_wr_data,
  output logic [31:0] o_mem_req_data,
  output logic        o_mem_req_ready
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
  localparam bit SINGLE_CYCLE = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_wr;
  logic [31:0]             r_wdata;
  logic [31:0]             r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   w_req_idx;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_wr;
  logic [31:0]             w_wdata;
  logic                    w_accept;
  logic                    w_commit;
  logic                    w_unused_addr;

  assign w_req_idx     = i_mem_req_addr[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^{i_mem_req_addr[31:ADDR_WIDTH+2], i_mem_req_addr[1:0]};
  assign w_accept      = (r_state == S_IDLE) && i_mem_req_valid;

  // A single-cycle build commits on the accepting edge, so bypass the latches there.
  assign w_idx   = (r_state == S_IDLE) ? w_req_idx     : r_addr;
  assign w_wr    = (r_state == S_IDLE) ? i_mem_req_wr  : r_wr;
  assign w_wdata = (r_state == S_IDLE) ? i_mem_wr_data : r_wdata;

  // The commit edge is the edge that enters DONE; reset on that edge drops it.
  assign w_commit = !rst && (r_state != S_DONE) && (w_state_nxt == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_mem_req_valid) begin
          if (SINGLE_CYCLE) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_BUSY: begin
        if (!i_mem_req_valid) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request snapshot, held for the remainder of the transaction.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= w_req_idx;
      r_wr    <= i_mem_req_wr;
      r_wdata <= i_mem_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_mem_req_ready <= 1'b0;
      o_mem_req_data  <= 32'h0;
    end else begin
      o_mem_req_ready <= w_commit;
      if (w_commit && !w_wr) begin
        o_mem_req_data <= r_mem[w_idx];
      end
    end
  end

  // Array is never cleared by reset; it relies on zero power-up contents.
  always_ff @(posedge clk) begin
    if (w_commit && w_wr) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: a LATENCY=4 instance driven from a
// vector table plus corner sequences, and a LATENCY=1 instance.
module tb_cache_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] t_addr;
  logic        t_wr;
  logic [31:0] t_wd;
  logic        a_valid;
  logic        b_valid;
  logic [31:0] a_data;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst),
    .i_mem_req_addr(t_addr), .i_mem_req_valid(a_valid), .i_mem_req_wr(t_wr),
    .i_mem_wr_data(t_wd), .o_mem_req_data(a_data), .o_mem_req_ready(a_ready)
  );

  cache_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .i_mem_req_addr(t_addr), .i_mem_req_valid(b_valid), .i_mem_req_wr(t_wr),
    .i_mem_wr_data(t_wd), .o_mem_req_data(b_data), .o_mem_req_ready(b_ready)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction

  function automatic logic [31:0] rdata(input bit sel);
    return sel ? b_data : a_data;
  endfunction

  // Called at a negedge; returns at a negedge with the DUT idle again.
  task automatic txn(input bit sel, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, output int lat, output logic [31:0] rd,
                     output logic narrow);
    t_wr = wr; t_addr = addr; t_wd = wd;
    if (sel) b_valid = 1'b1; else a_valid = 1'b1;
    lat = 0;
    rd  = 32'hBAD0_BAD0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rdy(sel)) begin
        lat = k;
        rd  = rdata(sel);
        break;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    narrow = !rdy(sel);
  endtask

  vec_t        vecs[7];
  int          lat;
  logic [31:0] rd;
  logic        narrow;
  logic [31:0] last_rd;
  int          pulses[3];
  int          np;
  int          seen;

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_1013, 32'h1234_5678, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678};
    vecs[4] = '{1'b0, 32'h0000_0014, 32'h0,         32'h0};
    vecs[5] = '{1'b1, 32'h0000_0020, 32'hCAFE_0001, 32'h0};
    vecs[6] = '{1'b0, 32'hFFFF_F020, 32'h0,         32'hCAFE_0001};

    // Reset held with a request pending.
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b0; t_wr = 1'b0; t_addr = 32'h0; t_wd = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(a_ready), 32'h0);
      chk("rst_data", a_data, 32'h0);
    end
    rst = 1'b0;
    txn(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, narrow);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_data", rd, 32'h0);
    last_rd = 32'h0;

    // Table: latency, pulse width, read data (writes keep prior read data).
    for (int i = 0; i < 7; i++) begin
      txn(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rd, narrow);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_narrow", i), 32'(narrow), 32'h1);
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d_wr_hold", i), rd, last_rd);
      end else begin
        chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        last_rd = vecs[i].exp_rd;
      end
    end

    // Back-to-back reads with valid held continuously.
    t_wr = 1'b0; t_addr = 32'h0000_0010; a_valid = 1'b1;
    np = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (a_ready) begin
        pulses[np] = k;
        chk($sformatf("b2b_data%0d", np), a_data, 32'h1234_5678);
        np++;
        if (np == 3) begin
          a_valid = 1'b0;
          break;
        end
      end
    end
    chk("b2b_count", 32'(np), 32'd3);
    chk("b2b_first", 32'(pulses[0]), 32'd4);
    chk("b2b_gap1", 32'(pulses[1] - pulses[0]), 32'd5);
    chk("b2b_gap2", 32'(pulses[2] - pulses[1]), 32'd5);
    @(negedge clk);
    chk("b2b_tail_ready", 32'(a_ready), 32'h0);

    // Abort: write dropped when valid falls two cycles after acceptance.
    t_wr = 1'b1; t_addr = 32'h0000_0020; t_wd = 32'hAAAA_AAAA; a_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (a_ready) seen++;
    end
    chk("abort_no_ready", 32'(seen), 32'd0);
    txn(1'b0, 1'b0, 32'h0000_0020, 32'h0, lat, rd, narrow);
    chk("abort_rd_lat", 32'(lat), 32'd4);
    chk("abort_rd", rd, 32'hCAFE_0001);

    // Reset mid-transaction drops an uncommitted write.
    t_wr = 1'b1; t_addr = 32'h0000_0030; t_wd = 32'h7777_7777; a_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_valid = 1'b0;
    chk("midrst_ready", 32'(a_ready), 32'h0);
    txn(1'b0, 1'b0, 32'h0000_0030, 32'h0, lat, rd, narrow);
    chk("midrst_rd_lat", 32'(lat), 32'd4);
    chk("midrst_rd", rd, 32'h0);

    // LATENCY=1 instance.
    txn(1'b1, 1'b1, 32'h0000_0040, 32'h55AA_55AA, lat, rd, narrow);
    chk("l1_wr_lat", 32'(lat), 32'd1);
    chk("l1_wr_narrow", 32'(narrow), 32'h1);
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, lat, rd, narrow);
    chk("l1_rd_lat", 32'(lat), 32'd1);
    chk("l1_rd", rd, 32'h55AA_55AA);

    // Reset asserted while in DONE.
    t_wr = 1'b0; t_addr = 32'h0000_0040; b_valid = 1'b1;
    @(negedge clk);
    chk("l1_done_ready", 32'(b_ready), 32'h1);
    rst = 1'b1; b_valid = 1'b0;
    @(negedge clk);
    chk("l1_rst_ready", 32'(b_ready), 32'h0);
    chk("l1_rst_data", b_data, 32'h0);
    rst = 1'b0;
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, lat, rd, narrow);
    chk("l1_after_rst_lat", 32'(lat), 32'd1);
    chk("l1_after_rst_rd", rd, 32'h55AA_55AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
